// File: rtl/cpu_pkg.sv
// Shared encodings for the execute stage: opcodes, condition codes, shift types,
// FSM states, CPSR bit positions and the ARM condition evaluator.
package cpu_pkg;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;

  localparam int CPSR_N = 3;
  localparam int CPSR_Z = 2;
  localparam int CPSR_C = 1;
  localparam int CPSR_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] cpsr);
    logic n, z, c, v;
    n = cpsr[CPSR_N];
    z = cpsr[CPSR_Z];
    c = cpsr[CPSR_C];
    v = cpsr[CPSR_V];
    case (cond)
      COND_EQ: return z;
      COND_NE: return !z;
      COND_CS: return c;
      COND_CC: return !c;
      COND_MI: return n;
      COND_PL: return !n;
      COND_VS: return v;
      COND_VC: return !v;
      COND_HI: return c && !z;
      COND_LS: return !c || z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return !z && (n == v);
      COND_LE: return z || (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational data-processing unit: opcode -> result, carry-out and overflow.
// Subtracts are formed as x + ~y + cin so one adder serves every arithmetic op.
module alu_core
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              c_in,
  input  logic              sh_carry,
  output logic [DATA_W-1:0] res,
  output logic              c_out,
  output logic              v_out,
  output logic              arith
);

  logic [DATA_W-1:0] x, y;
  logic              cin;
  logic [DATA_W:0]   sum;

  always_comb begin
    x     = a;
    y     = b;
    cin   = 1'b0;
    arith = 1'b1;
    case (opcode)
      OP_SUB, OP_CMP: begin y = ~b; cin = 1'b1; end
      OP_RSB:         begin x = b; y = ~a; cin = 1'b1; end
      OP_ADD, OP_CMN: cin = 1'b0;
      OP_ADC:         cin = c_in;
      OP_SBC:         begin y = ~b; cin = c_in; end
      OP_RSC:         begin x = b; y = ~a; cin = c_in; end
      default:        arith = 1'b0;
    endcase
    sum = {1'b0, x} + {1'b0, y} + {{DATA_W{1'b0}}, cin};

    res   = sum[DATA_W-1:0];
    c_out = sum[DATA_W];
    v_out = (x[DATA_W-1] == y[DATA_W-1]) && (sum[DATA_W-1] != x[DATA_W-1]);
    if (!arith) begin
      c_out = sh_carry;
      v_out = 1'b0;
      case (opcode)
        OP_AND, OP_TST: res = a & b;
        OP_EOR, OP_TEQ: res = a ^ b;
        OP_ORR:         res = a | b;
        OP_MOV:         res = b;
        OP_BIC:         res = a & ~b;
        default:        res = ~b;
      endcase
    end
  end

endmodule

// File: rtl/alu_execute.sv
// Execute stage: condition check, operand-2 shift, ALU op, NZCV ownership.
// ALU_EXECUTE_BARREL_EN selects a single-cycle barrel shifter in place of the iterative one.
module alu_execute
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         opcode,
  input  logic [3:0]         cond,
  input  logic               s_bit,
  input  logic [DATA_W-1:0]  op_a,
  input  logic [DATA_W-1:0]  op_b,
  input  logic [1:0]         sh_type,
  input  logic [SHAMT_W-1:0] sh_amt,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  result,
  output logic               wr_en,
  output logic               cond_pass,
  output logic [3:0]         cpsr
);

  state_t              state, state_nxt;
  logic [3:0]          opc_q;
  logic                s_q, c_in_q, sh_c_q, wr_q, pass_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [1:0]          sht_q;
  logic [SHAMT_W-1:0]  cnt_q;
  logic                cond_ok, is_test;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c, alu_v, alu_arith;

  // Returns {carry_out, shifted_value} for a single-position shift.
  function automatic logic [DATA_W:0] shift1(input logic [DATA_W-1:0] v, input logic [1:0] t);
    case (t)
      SH_LSL:  return {v[DATA_W-1], v[DATA_W-2:0], 1'b0};
      SH_LSR:  return {v[0], 1'b0, v[DATA_W-1:1]};
      SH_ASR:  return {v[0], v[DATA_W-1], v[DATA_W-1:1]};
      default: return {v[0], v[0], v[DATA_W-1:1]};
    endcase
  endfunction

`ifdef ALU_EXECUTE_BARREL_EN
  function automatic logic [DATA_W:0] barrel(input logic [DATA_W-1:0] v, input logic [1:0] t,
                                             input logic [SHAMT_W-1:0] n, input logic c_old);
    logic [DATA_W:0]   ext;
    logic [DATA_W-1:0] r;
    if (n == '0) return {c_old, v};
    case (t)
      SH_LSL: begin ext = {1'b0, v} << n; return ext; end
      SH_LSR: begin ext = {v, 1'b0} >> n; return {ext[0], ext[DATA_W:1]}; end
      SH_ASR: begin ext = $signed({v, 1'b0}) >>> n; return {ext[0], ext[DATA_W:1]}; end
      default: begin
        r = (v >> n) | (v << (DATA_W - int'(n)));
        return {r[DATA_W-1], r};
      end
    endcase
  endfunction
`endif

  assign cond_ok   = cond_check(cond, cpsr);
  assign is_test   = (opc_q[3:2] == 2'b10);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign wr_en     = done && wr_q;
  assign cond_pass = done && pass_q;

  alu_core #(.DATA_W(DATA_W)) u_alu_core (
    .opcode   (opc_q),
    .a        (a_q),
    .b        (b_q),
    .c_in     (c_in_q),
    .sh_carry (sh_c_q),
    .res      (alu_res),
    .c_out    (alu_c),
    .v_out    (alu_v),
    .arith    (alu_arith)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (!cond_ok) state_nxt = ST_DONE;
`ifdef ALU_EXECUTE_BARREL_EN
          else state_nxt = ST_COMPUTE;
`else
          else if (sh_amt == '0) state_nxt = ST_COMPUTE;
          else state_nxt = ST_SHIFT;
`endif
        end
      end
      ST_SHIFT:   if (cnt_q == SHAMT_W'(1)) state_nxt = ST_COMPUTE;
      ST_COMPUTE: state_nxt = ST_DONE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opc_q  <= '0;
      s_q    <= 1'b0;
      c_in_q <= 1'b0;
      sh_c_q <= 1'b0;
      wr_q   <= 1'b0;
      pass_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sht_q  <= '0;
      cnt_q  <= '0;
      result <= '0;
      cpsr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            opc_q  <= opcode;
            s_q    <= s_bit;
            a_q    <= op_a;
            sht_q  <= sh_type;
            cnt_q  <= sh_amt;
            c_in_q <= cpsr[CPSR_C];
            pass_q <= cond_ok;
            wr_q   <= 1'b0;
`ifdef ALU_EXECUTE_BARREL_EN
            {sh_c_q, b_q} <= barrel(op_b, sh_type, sh_amt, cpsr[CPSR_C]);
`else
            b_q    <= op_b;
            sh_c_q <= cpsr[CPSR_C];
`endif
          end
        end
        ST_SHIFT: begin
          {sh_c_q, b_q} <= shift1(b_q, sht_q);
          cnt_q         <= cnt_q - SHAMT_W'(1);
        end
        ST_COMPUTE: begin
          wr_q <= !is_test;
          if (!is_test) result <= alu_res;
          // Compare/test ops exist only to set flags, so they ignore the S bit.
          if (s_q || is_test) begin
            cpsr[CPSR_N] <= alu_res[DATA_W-1];
            cpsr[CPSR_Z] <= (alu_res == '0);
            cpsr[CPSR_C] <= alu_c;
            if (alu_arith) cpsr[CPSR_V] <= alu_v;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_execute.sv
// Scoreboard bench for alu_execute: directed cases plus random ops against a
// plain-arithmetic reference model; a monitor compares whenever done pulses.
module tb_alu_execute;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  opcode = '0;
  logic [3:0]  cond = '0;
  logic        s_bit = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [1:0]  sh_type = '0;
  logic [4:0]  sh_amt = '0;
  logic        busy, done, wr_en, cond_pass;
  logic [31:0] result;
  logic [3:0]  cpsr;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    logic        wr;
    logic        pass;
    logic [3:0]  flags;
    int          lat;
    int          t0;
  } exp_t;

  exp_t        q[$];
  logic [3:0]  m_cpsr = '0;
  logic [31:0] m_result = '0;

  alu_execute #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .cond(cond),
    .s_bit(s_bit), .op_a(op_a), .op_b(op_b), .sh_type(sh_type), .sh_amt(sh_amt),
    .busy(busy), .done(done), .result(result), .wr_en(wr_en),
    .cond_pass(cond_pass), .cpsr(cpsr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endfunction

  function automatic logic m_cond(logic [3:0] c, logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      0: return z;             1: return !z;
      2: return cy;            3: return !cy;
      4: return n;             5: return !n;
      6: return v;             7: return !v;
      8: return cy & !z;       9: return !cy | z;
      10: return n == v;       11: return n != v;
      12: return !z & (n == v); 13: return z | (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic ovf(longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic model(input logic [3:0] opc, input logic [3:0] cnd, input logic s,
                       input logic [31:0] a, input logic [31:0] b, input logic [1:0] t,
                       input int n, output exp_t e);
    logic [31:0] sv, r;
    logic        sc, c, v, ci, test;
    logic [63:0] ua, ub, full, bw;
    longint      sa, sb, ss;
    e.pass = m_cond(cnd, m_cpsr);
    if (!e.pass) begin
      e.lat = 1; e.wr = 1'b0; e.res = m_result; e.flags = m_cpsr;
      return;
    end
`ifdef ALU_EXECUTE_BARREL_EN
    e.lat = 2;
`else
    e.lat = 2 + n;
`endif
    sv = b; sc = m_cpsr[1];
    if (n > 0) begin
      case (t)
        0: begin sv = b << n; sc = b[32-n]; end
        1: begin sv = b >> n; sc = b[n-1]; end
        2: begin sv = $signed(b) >>> n; sc = b[n-1]; end
        default: begin sv = (b >> n) | (b << (32 - n)); sc = sv[31]; end
      endcase
    end
    ci = m_cpsr[1];
    bw = ci ? 64'd0 : 64'd1;
    ua = {32'd0, a};
    ub = {32'd0, sv};
    sa = longint'($signed(a));
    sb = longint'($signed(sv));
    c = sc; v = m_cpsr[0]; r = '0;
    case (opc)
      4'h4, 4'hB: begin full = ua + ub; r = full[31:0]; c = full[32]; v = ovf(sa + sb); end
      4'h5: begin full = ua + ub + {63'd0, ci}; r = full[31:0]; c = full[32];
                  v = ovf(sa + sb + longint'(ci)); end
      4'h2, 4'hA: begin r = a - sv; c = (ua >= ub); v = ovf(sa - sb); end
      4'h6: begin r = a - sv - bw[31:0]; c = (ua >= ub + bw); ss = sa - sb - longint'(bw);
                  v = ovf(ss); end
      4'h3: begin r = sv - a; c = (ub >= ua); v = ovf(sb - sa); end
      4'h7: begin r = sv - a - bw[31:0]; c = (ub >= ua + bw); ss = sb - sa - longint'(bw);
                  v = ovf(ss); end
      4'h0, 4'h8: r = a & sv;
      4'h1, 4'h9: r = a ^ sv;
      4'hC: r = a | sv;
      4'hD: r = sv;
      4'hE: r = a & ~sv;
      default: r = ~sv;
    endcase
    test = (opc >= 4'h8) && (opc <= 4'hB);
    e.wr = !test;
    if (!test) m_result = r;
    if (s || test) m_cpsr = {r[31], r == 32'd0, c, v};
    e.res = m_result;
    e.flags = m_cpsr;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        chk("latency", 64'(cyc - e.t0), 64'(e.lat));
        chk("cond_pass", {63'd0, cond_pass}, {63'd0, e.pass});
        chk("wr_en", {63'd0, wr_en}, {63'd0, e.wr});
        chk("result", {32'd0, result}, {32'd0, e.res});
        chk("cpsr", {60'd0, cpsr}, {60'd0, e.flags});
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic issue(input logic [3:0] opc, input logic [3:0] cnd, input logic s,
                       input logic [31:0] a, input logic [31:0] b, input logic [1:0] t,
                       input logic [4:0] n);
    exp_t e;
    wait_idle();
    model(opc, cnd, s, a, b, t, int'(n), e);
    e.t0 = cyc;
    q.push_back(e);
    opcode = opc; cond = cnd; s_bit = s; op_a = a; op_b = b; sh_type = t; sh_amt = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    opcode = 4'($urandom); cond = 4'($urandom); s_bit = 1'($urandom);
    op_a = $urandom; op_b = $urandom; sh_type = 2'($urandom); sh_amt = 5'($urandom);
    chk("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_wr_en"}, {63'd0, wr_en}, 64'd0);
    chk({tag, "_cond_pass"}, {63'd0, cond_pass}, 64'd0);
    chk({tag, "_result"}, {32'd0, result}, 64'd0);
    chk({tag, "_cpsr"}, {60'd0, cpsr}, 64'd0);
  endtask

  initial begin
    int n;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases from the intended use of the block.
    issue(4'h4, 4'hE, 1'b1, 32'h7FFFFFFF, 32'd1, 2'd0, 5'd0);
    issue(4'h2, 4'h0, 1'b1, 32'd5, 32'd5, 2'd0, 5'd0);
    issue(4'hD, 4'hE, 1'b1, 32'd0, 32'h80000001, 2'd1, 5'd3);
    issue(4'hD, 4'hE, 1'b1, 32'd0, 32'h80000001, 2'd2, 5'd1);
    issue(4'hA, 4'hE, 1'b0, 32'd3, 32'd3, 2'd0, 5'd0);
    issue(4'h5, 4'hE, 1'b0, 32'd1, 32'd1, 2'd0, 5'd0);

    // Starts while busy must be ignored.
    issue(4'hD, 4'hE, 1'b1, 32'd0, 32'h12345678, 2'd3, 5'd31);
    for (int i = 0; i < 6; i++) begin
      if (busy) start = 1'b1;
      opcode = 4'h4; cond = 4'hE; op_a = $urandom; op_b = $urandom; sh_amt = 5'd0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
    end

    // Reset in the middle of a shift.
    issue(4'hD, 4'hE, 1'b1, 32'd0, 32'hF0F0F0F0, 2'd0, 5'd20);
    repeat (3) @(negedge clk);
    chk("busy_before_abort", {63'd0, busy}, 64'd1);
    #2 rst = 1'b1;
    #1 check_zero("abort");
    q.delete();
    m_cpsr = '0;
    m_result = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(4'h4, 4'hE, 1'b1, 32'd10, 32'd20, 2'd0, 5'd2);

    // Random traffic; condition codes evolve with the flags they depend on.
    for (int i = 0; i < 150; i++) begin
      issue(4'($urandom), 4'($urandom_range(0, 15)), 1'($urandom),
            $urandom, $urandom, 2'($urandom), 5'($urandom));
    end

    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
